ifu_pfq: RTL and testbench

Parametrised instruction fetch unit with a prefetch queue. It replaces the single-entry fetch stage between instruction SRAM0 and the decoder/execute stage. It keeps up to DEPTH instructions in flight or queued, and presents them in order with a valid/ready handshake. It supports branch redirect and hazard flush-with-replay, and sustains one instruction per cycle while the consumer is ready.

---
 rtl/core_pkg.sv | 14 +
 rtl/pfq_fifo.sv | 73 +++++++
 rtl/ifu_pfq.sv | 110 +++++++++++
 tb/tb_ifu_pfq.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared fetch-path types and constants.
package core_pkg;

   localparam int unsigned CORE_XLEN = 32;
   localparam int unsigned ILEN      = 32;

   localparam logic [CORE_XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

   typedef struct packed {
      logic [CORE_XLEN-1:0] pc;
      logic [ILEN-1:0]      ins;
   } fetch_entry_t;

endpackage

// File: rtl/pfq_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries; clr overrides push and pop.
module pfq_fifo
   import core_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned CW = $clog2(DEPTH + 1),
   localparam int unsigned PW = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         push,
   input  fetch_entry_t wdata,
   input  logic         pop,
   input  logic         clr,
   output logic [CW-1:0] count,
   output fetch_entry_t head
);

   fetch_entry_t   mem_q [DEPTH];
   fetch_entry_t   mem_d [DEPTH];
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  count_q, count_d;
   logic           do_push, do_pop;

   always_comb begin
      do_push  = push & ~clr;
      do_pop   = pop & ~clr & (count_q != '0);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PW'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

   a_count_range: assert property (@(posedge clk) disable iff (!rstn)
      count_q <= CW'(DEPTH));
   a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
      !(push && !pop && !clr && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/ifu_pfq.sv
// Instruction fetch unit: credit-limited SRAM0 issue feeding an in-order prefetch queue.
module ifu_pfq
   import core_pkg::*;
#(
   parameter int unsigned    XLEN     = CORE_XLEN,
   parameter int unsigned    IA_W     = 16,
   parameter int unsigned    DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            branch,
   input  logic [XLEN-1:0] br_adr,
   input  logic            flush,
   output logic            ifu_vld,
   input  logic            ifu_rdy,
   output logic [XLEN-1:0] ifu_pc,
   output logic [31:0]     ifu_ins,
   output logic [IA_W-1:0] ins_a,
   output logic            ins_e,
   input  logic [31:0]     ins
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic            run_q, run_d;
   logic            inflight_q, inflight_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] replay_pc_q, replay_pc_d;
   logic [XLEN-1:0] resp_pc_q, resp_pc_d;

   logic [CW-1:0]   count;
   logic [CW:0]     credit_used;
   fetch_entry_t    head, wr_entry;
   logic            kill, pop, issue;
   logic [XLEN-1:0] br_tgt, replay_nxt;
   logic            unused_br_lsb;

   assign unused_br_lsb = ^br_adr[1:0];

   assign kill   = branch | flush;
   assign pop    = ifu_vld & ifu_rdy;
   assign br_tgt = {br_adr[XLEN-1:2], 2'b00};

   // Credits ignore a same-cycle pop, so a returning response always has a free slot.
   assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight_q};
   assign issue       = run_q & ~kill & (credit_used < (CW + 1)'(DEPTH));

   // A pop during a kill cycle still advances the replay point.
   assign replay_nxt = pop ? (ifu_pc + XLEN'(4)) : replay_pc_q;

   always_comb begin
      run_d       = 1'b1;
      inflight_d  = issue;
      resp_pc_d   = issue ? fetch_pc_q : resp_pc_q;
      fetch_pc_d  = fetch_pc_q;
      replay_pc_d = replay_nxt;
      if (branch) begin
         fetch_pc_d  = br_tgt;
         replay_pc_d = br_tgt;
      end else if (flush) begin
         fetch_pc_d = replay_nxt;
      end else if (issue) begin
         fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         run_q       <= 1'b0;
         inflight_q  <= 1'b0;
         fetch_pc_q  <= RESET_PC;
         replay_pc_q <= RESET_PC;
         resp_pc_q   <= '0;
      end else begin
         run_q       <= run_d;
         inflight_q  <= inflight_d;
         fetch_pc_q  <= fetch_pc_d;
         replay_pc_q <= replay_pc_d;
         resp_pc_q   <= resp_pc_d;
      end
   end

   assign wr_entry.pc  = resp_pc_q;
   assign wr_entry.ins = ins;

   // Kill clears the queue and thereby drops a response landing in the same cycle.
   pfq_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (inflight_q),
      .wdata (wr_entry),
      .pop   (pop),
      .clr   (kill),
      .count (count),
      .head  (head)
   );

   assign ins_e   = issue;
   assign ins_a   = run_q ? fetch_pc_q[IA_W+1:2] : '0;
   assign ifu_vld = (count != '0);
   assign ifu_pc  = head.pc;
   assign ifu_ins = head.ins;

   a_pc_aligned: assert property (@(posedge clk) disable iff (!rstn)
      ifu_pc[1:0] == 2'b00);

endmodule

// File: tb/tb_ifu_pfq.sv
// Directed bench for ifu_pfq: streaming, back-pressure, branch, flush, wrap and reset.
module tb_ifu_pfq;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        branch = 1'b0;
   logic [31:0] br_adr = '0;
   logic        flush = 1'b0;
   logic        ifu_vld;
   logic        ifu_rdy = 1'b0;
   logic [31:0] ifu_pc;
   logic [31:0] ifu_ins;
   logic [15:0] ins_a;
   logic        ins_e;
   logic [31:0] ins = 32'hDEAD_BEEF;

   int n_err = 0;
   int n_chk = 0;
   int issues;

   always #5 clk = ~clk;

   // SRAM0 model: one-cycle latency, returns the word address as data.
   always @(posedge clk) begin
      if (ins_e) ins <= {16'h0000, ins_a};
      else       ins <= 32'hDEAD_BEEF;
   end

   ifu_pfq dut (
      .clk     (clk),
      .rstn    (rstn),
      .branch  (branch),
      .br_adr  (br_adr),
      .flush   (flush),
      .ifu_vld (ifu_vld),
      .ifu_rdy (ifu_rdy),
      .ifu_pc  (ifu_pc),
      .ifu_ins (ifu_ins),
      .ins_a   (ins_a),
      .ins_e   (ins_e),
      .ins     (ins)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_head(input string tag, input logic [31:0] pc);
      logic [31:0] e_ins;
      e_ins = {16'h0000, pc[17:2]};
      check_eq({tag, "_vld"}, {31'b0, ifu_vld}, 32'd1);
      check_eq({tag, "_pc"}, ifu_pc, pc);
      check_eq({tag, "_ins"}, ifu_ins, e_ins);
   endtask

   // Drive one cycle's inputs at the falling edge; outputs are checked 1 ns later.
   task automatic cyc(input logic br, input logic fl, input logic [31:0] adr, input logic rdy);
      @(negedge clk);
      branch  = br;
      flush   = fl;
      br_adr  = adr;
      ifu_rdy = rdy;
      #1;
   endtask

   task automatic do_reset(input logic rdy);
      @(negedge clk);
      rstn    = 1'b0;
      branch  = 1'b0;
      flush   = 1'b0;
      ifu_rdy = rdy;
      #1;
      check_eq("rst_vld", {31'b0, ifu_vld}, 32'd0);
      check_eq("rst_ins_e", {31'b0, ins_e}, 32'd0);
      check_eq("rst_ins_a", {16'b0, ins_a}, 32'd0);
      check_eq("rst_pc", ifu_pc, 32'd0);
      check_eq("rst_ins", ifu_ins, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      #1;
      check_eq("rel_ins_e", {31'b0, ins_e}, 32'd0);
   endtask

   initial begin
      // Streaming from reset with the consumer always ready.
      do_reset(1'b1);
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      check_eq("t1_c1_ins_e", {31'b0, ins_e}, 32'd1);
      check_eq("t1_c1_ins_a", {16'b0, ins_a}, 32'h0);
      check_eq("t1_c1_vld", {31'b0, ifu_vld}, 32'd0);
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      check_eq("t1_c2_vld", {31'b0, ifu_vld}, 32'd0);
      check_eq("t1_c2_ins_a", {16'b0, ins_a}, 32'h1);
      for (int k = 0; k < 8; k++) begin
         cyc(1'b0, 1'b0, 32'h0, 1'b1);
         check_head("t1_stream", 32'(4 * k));
         check_eq("t1_stream_ins_e", {31'b0, ins_e}, 32'd1);
      end

      // Back-pressure from reset: credits stop issue after DEPTH fetches.
      do_reset(1'b0);
      issues = 0;
      for (int c = 1; c <= 10; c++) begin
         cyc(1'b0, 1'b0, 32'h0, 1'b0);
         issues += int'(ins_e);
         if (c >= 3) check_head("t2_hold", 32'h0);
      end
      check_eq("t2_issues", 32'(issues), 32'd4);
      for (int k = 0; k < 6; k++) begin
         cyc(1'b0, 1'b0, 32'h0, 1'b1);
         check_head("t2_drain", 32'(4 * k));
         if (k == 0) check_eq("t2_c11_ins_e", {31'b0, ins_e}, 32'd0);
         if (k == 1) check_eq("t2_c12_ins_a", {16'b0, ins_a}, 32'h4);
      end

      // Fill to 3 queued + 1 in flight, then branch to 0x103.
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      check_head("t3_pre", 32'h18);
      cyc(1'b1, 1'b0, 32'h103, 1'b0);
      check_eq("t3_T_ins_e", {31'b0, ins_e}, 32'd0);
      check_head("t3_T", 32'h18);
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      check_eq("t3_T1_vld", {31'b0, ifu_vld}, 32'd0);
      check_eq("t3_T1_ins_e", {31'b0, ins_e}, 32'd1);
      check_eq("t3_T1_ins_a", {16'b0, ins_a}, 32'h40);
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      check_eq("t3_T2_vld", {31'b0, ifu_vld}, 32'd0);
      check_eq("t3_T2_ins_a", {16'b0, ins_a}, 32'h41);
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      check_head("t3_T3", 32'h100);
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      check_head("t3_T4", 32'h104);

      // Branch to 0x20, then flush while popping 0x20: replay from 0x24.
      cyc(1'b1, 1'b0, 32'h20, 1'b1);
      check_eq("t4_br_ins_e", {31'b0, ins_e}, 32'd0);
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      check_eq("t4_U1_vld", {31'b0, ifu_vld}, 32'd0);
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      cyc(1'b0, 1'b1, 32'h0, 1'b1);
      check_head("t4_flush", 32'h20);
      check_eq("t4_flush_ins_e", {31'b0, ins_e}, 32'd0);
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      check_eq("t4_F1_vld", {31'b0, ifu_vld}, 32'd0);
      check_eq("t4_F1_ins_a", {16'b0, ins_a}, 32'h9);
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      check_eq("t4_F2_vld", {31'b0, ifu_vld}, 32'd0);
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      check_head("t4_F3", 32'h24);
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      check_head("t4_F4", 32'h28);

      // Branch and flush together: branch target wins.
      cyc(1'b1, 1'b1, 32'h200, 1'b1);
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      check_eq("t5_ins_a", {16'b0, ins_a}, 32'h80);
      check_eq("t5_vld", {31'b0, ifu_vld}, 32'd0);
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      check_head("t5_head", 32'h200);

      // PC wrap at the top of the address space.
      cyc(1'b1, 1'b0, 32'hFFFF_FFFC, 1'b1);
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      check_eq("t6_ins_a_top", {16'b0, ins_a}, 32'hFFFF);
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      check_eq("t6_ins_a_wrap", {16'b0, ins_a}, 32'h0);
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      check_head("t6_top", 32'hFFFF_FFFC);
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      check_head("t6_wrap", 32'h0);
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      check_head("t6_next", 32'h4);

      // Reset mid-stream, then restart from RESET_PC.
      do_reset(1'b1);
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      check_eq("t6_rs_ins_e", {31'b0, ins_e}, 32'd1);
      check_eq("t6_rs_ins_a", {16'b0, ins_a}, 32'h0);
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      check_eq("t6_rs_c2_vld", {31'b0, ifu_vld}, 32'd0);
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      check_head("t6_rs_c3", 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
